// File: rtl/kij_seq_pkg.sv
// kij_seq_pkg
// Shared types and constants for the kij sequencer and its L0 feeder.
//   - array geometry (ROW, COL, BW, NUM_INP) and the xmem address map
//   - derived widths for the L0 word, kij counter, psum address and feeder counters
//   - FSM state enum and core instruction encodings
//   - helpers computing the xmem base address of the weight / activation block for pass k
package kij_seq_pkg;

   localparam int ROW      = 4;
   localparam int COL      = 4;
   localparam int BW       = 8;
   localparam int NUM_INP  = 8;
   localparam int KIJ_MAX  = 9;
   localparam int ADDR_W   = 11;
   localparam int W_BASE   = 0;
   localparam int A_BASE   = 1024;

   localparam int WORD_W     = BW * ROW;
   localparam int KIJ_W      = $clog2(KIJ_MAX + 1);
   localparam int PSUM_AW    = $clog2(NUM_INP);
   localparam int CNT_W      = $clog2(((COL > NUM_INP) ? COL : NUM_INP) + 1);
   localparam int SETTLE_CYC = ROW + COL;
   localparam int SET_W      = $clog2(SETTLE_CYC + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      SETTLE,
      EXEC,
      DRAIN,
      NEXT,
      FIN
   } state_t;

   localparam logic [1:0] INST_IDLE  = 2'b00;
   localparam logic [1:0] INST_KLOAD = 2'b01;
   localparam logic [1:0] INST_EXEC  = 2'b10;

   // Weight block for pass k starts COL words after the block of pass k-1.
   function automatic logic [ADDR_W-1:0] weightBase(input logic [KIJ_W-1:0] k);
      return ADDR_W'(W_BASE) + ADDR_W'(k) * ADDR_W'(COL);
   endfunction

   // Activation block for pass k starts NUM_INP words after the block of pass k-1.
   function automatic logic [ADDR_W-1:0] actBase(input logic [KIJ_W-1:0] k);
      return ADDR_W'(A_BASE) + ADDR_W'(k) * ADDR_W'(NUM_INP);
   endfunction

endpackage

// File: rtl/l0_feeder.sv
// l0_feeder
// Streams count_i consecutive xmem words starting at base_i into L0, honouring L0 backpressure.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   active_i         FSM is in a feeding state (LOAD_W or EXEC)
//   base_i, count_i  first xmem address and number of words for this block
//   l0_full_i        L0 backpressure
//   xmem_dout_i      xmem read data, valid one cycle after xmem_rd_o
//   xmem_rd_o        xmem read strobe
//   xmem_addr_o      xmem read address (0 when not reading)
//   l0_wr_o          L0 write strobe
//   l0_din_o         L0 write data (0 when not writing)
//   last_o           the final word of the block is being written this cycle
module l0_feeder
   import kij_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              active_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [CNT_W-1:0]  count_i,
   input  logic              l0_full_i,
   input  logic [WORD_W-1:0] xmem_dout_i,
   output logic              xmem_rd_o,
   output logic [ADDR_W-1:0] xmem_addr_o,
   output logic              l0_wr_o,
   output logic [WORD_W-1:0] l0_din_o,
   output logic              last_o
);

   logic [CNT_W-1:0]  issued_q, issued_d;
   logic [CNT_W-1:0]  written_q, written_d;
   logic              inFlight_q;
   logic              holdValid_q, holdValid_d;
   logic [WORD_W-1:0] hold_q, hold_d;

   logic issue;
   logic writeHold;
   logic writeFlight;
   logic wrEn;
   logic lastWrite;

   // A read may only be issued when its data is guaranteed a home: L0 not full and the
   // holding register empty. Because of that rule the holding register and an in-flight
   // word never coexist, so the parked word and a fresh word can never compete for L0.
   // Both counters clear themselves on the last write so the next block starts from zero.
   always_comb begin
      issue       = active_i && (issued_q < count_i) && !l0_full_i && !holdValid_q;
      writeHold   = holdValid_q && !l0_full_i;
      writeFlight = inFlight_q && !l0_full_i;
      wrEn        = writeHold || writeFlight;
      lastWrite   = wrEn && (written_q == count_i - CNT_W'(1));

      issued_d    = issued_q;
      written_d   = written_q;
      holdValid_d = holdValid_q;
      hold_d      = hold_q;

      if (issue) begin
         issued_d = issued_q + CNT_W'(1);
      end
      if (wrEn) begin
         written_d = written_q + CNT_W'(1);
      end
      if (lastWrite) begin
         issued_d  = '0;
         written_d = '0;
      end

      if (inFlight_q && l0_full_i) begin
         holdValid_d = 1'b1;
         hold_d      = xmem_dout_i;
      end else if (writeHold) begin
         holdValid_d = 1'b0;
      end
   end

   // Feeder state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issued_q    <= '0;
         written_q   <= '0;
         inFlight_q  <= 1'b0;
         holdValid_q <= 1'b0;
         hold_q      <= '0;
      end else begin
         issued_q    <= issued_d;
         written_q   <= written_d;
         inFlight_q  <= issue;
         holdValid_q <= holdValid_d;
         hold_q      <= hold_d;
      end
   end

   assign xmem_rd_o   = issue;
   assign xmem_addr_o = issue ? (base_i + ADDR_W'(issued_q)) : '0;
   assign l0_wr_o     = wrEn;
   assign l0_din_o    = writeHold ? hold_q : (writeFlight ? xmem_dout_i : '0);
   assign last_o      = lastWrite;

endmodule

// File: rtl/kij_sequencer.sv
// kij_sequencer
// Runs kij_len passes of: load COL weight words into L0, let them settle, stream NUM_INP
// activation words, then drain the OFIFO into psum memory (accumulating for k>0 and
// applying ReLU on the final pass). Pulses done when the last pass has drained.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   start, kij_len, acc_en, relu_en launch pulse and per-run configuration
//   busy, done                      run in progress / one-cycle completion pulse
//   xmem_rd, xmem_addr, xmem_dout   shared activation/weight SRAM read port
//   l0_wr, l0_din, l0_full          L0 write port with backpressure
//   inst_w                          core instruction (kernel load / execute / idle)
//   ofifo_valid, ofifo_rd           OFIFO pop handshake
//   psum_wr, psum_addr, acc, relu   psum memory write port
module kij_sequencer
   import kij_seq_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [KIJ_W-1:0]   kij_len,
   input  logic               acc_en,
   input  logic               relu_en,
   output logic               busy,
   output logic               done,
   output logic               xmem_rd,
   output logic [ADDR_W-1:0]  xmem_addr,
   input  logic [WORD_W-1:0]  xmem_dout,
   output logic               l0_wr,
   output logic [WORD_W-1:0]  l0_din,
   input  logic               l0_full,
   output logic [1:0]         inst_w,
   input  logic               ofifo_valid,
   output logic               ofifo_rd,
   output logic               psum_wr,
   output logic [PSUM_AW-1:0] psum_addr,
   output logic               acc,
   output logic               relu
);

   state_t             state_q;
   logic [KIJ_W-1:0]   kCnt_q;
   logic [KIJ_W-1:0]   kijLen_q;
   logic               accEn_q;
   logic               reluEn_q;
   logic               busy_q;
   logic               done_q;
   logic [1:0]         instW_q;
   logic [SET_W-1:0]   settleCnt_q;
   logic [PSUM_AW-1:0] drainCnt_q;

   logic               feedActive;
   logic [ADDR_W-1:0]  feedBase;
   logic [CNT_W-1:0]   feedCount;
   logic               feedLast;
   logic               popNow;
   logic               lastPass;

   // The feeder is shared: LOAD_W hands it the weight block, EXEC the activation block.
   always_comb begin
      feedActive = 1'b0;
      feedBase   = '0;
      feedCount  = '0;
      case (state_q)
         LOAD_W: begin
            feedActive = 1'b1;
            feedBase   = weightBase(kCnt_q);
            feedCount  = CNT_W'(COL);
         end
         EXEC: begin
            feedActive = 1'b1;
            feedBase   = actBase(kCnt_q);
            feedCount  = CNT_W'(NUM_INP);
         end
         default: ;
      endcase
   end

   l0_feeder uFeeder (
      .clk         (clk),
      .reset_n     (reset_n),
      .active_i    (feedActive),
      .base_i      (feedBase),
      .count_i     (feedCount),
      .l0_full_i   (l0_full),
      .xmem_dout_i (xmem_dout),
      .xmem_rd_o   (xmem_rd),
      .xmem_addr_o (xmem_addr),
      .l0_wr_o     (l0_wr),
      .l0_din_o    (l0_din),
      .last_o      (feedLast)
   );

   // The pop and the psum write must land in the same cycle, so they follow ofifo_valid
   // directly; the drain counter guarantees DRAIN is left right after the last row.
   always_comb begin
      popNow   = (state_q == DRAIN) && ofifo_valid;
      lastPass = (kCnt_q == kijLen_q - KIJ_W'(1));
   end

   assign ofifo_rd  = popNow;
   assign psum_wr   = popNow;
   assign psum_addr = popNow ? drainCnt_q : '0;
   assign acc       = popNow && accEn_q && (kCnt_q != '0);
   assign relu      = popNow && reluEn_q && lastPass;

   // Pass sequencer. LOAD_W and EXEC wait for the feeder's last L0 write, not the last
   // read, so a backpressured tail word is never left behind. done is raised on the way
   // out of FIN, which puts it two cycles after start for an empty run and keeps start
   // ignored during FIN itself.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         kCnt_q      <= '0;
         kijLen_q    <= '0;
         accEn_q     <= 1'b0;
         reluEn_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         instW_q     <= INST_IDLE;
         settleCnt_q <= '0;
         drainCnt_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q   <= 1'b1;
                  kijLen_q <= kij_len;
                  accEn_q  <= acc_en;
                  reluEn_q <= relu_en;
                  kCnt_q   <= '0;
                  if (kij_len != '0) begin
                     state_q <= LOAD_W;
                     instW_q <= INST_KLOAD;
                  end else begin
                     state_q <= FIN;
                  end
               end
            end
            LOAD_W: begin
               if (feedLast) begin
                  state_q     <= SETTLE;
                  settleCnt_q <= '0;
               end
            end
            SETTLE: begin
               if (settleCnt_q == SET_W'(SETTLE_CYC - 1)) begin
                  state_q <= EXEC;
                  instW_q <= INST_EXEC;
               end else begin
                  settleCnt_q <= settleCnt_q + SET_W'(1);
               end
            end
            EXEC: begin
               if (feedLast) begin
                  state_q    <= DRAIN;
                  instW_q    <= INST_IDLE;
                  drainCnt_q <= '0;
               end
            end
            DRAIN: begin
               if (popNow) begin
                  drainCnt_q <= drainCnt_q + PSUM_AW'(1);
                  if (drainCnt_q == PSUM_AW'(NUM_INP - 1)) begin
                     state_q <= NEXT;
                  end
               end
            end
            NEXT: begin
               kCnt_q <= kCnt_q + KIJ_W'(1);
               if (kCnt_q + KIJ_W'(1) == kijLen_q) begin
                  state_q <= FIN;
               end else begin
                  state_q <= LOAD_W;
                  instW_q <= INST_KLOAD;
               end
            end
            FIN: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               instW_q <= INST_IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign inst_w = instW_q;

endmodule

// File: tb/tb_kij_sequencer.sv
// tb_kij_sequencer
// Directed scoreboard bench for kij_sequencer: expected xmem reads, L0 writes and psum
// writes are queued when a run is launched and popped as the DUT produces them.
module tb_kij_sequencer;

   typedef struct {
      logic [31:0] val;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [3:0]  kij_len;
   logic        acc_en;
   logic        relu_en;
   logic        busy;
   logic        done;
   logic        xmem_rd;
   logic [10:0] xmem_addr;
   logic [31:0] xmem_dout = '0;
   logic        l0_wr;
   logic [31:0] l0_din;
   logic        l0_full;
   logic [1:0]  inst_w;
   logic        ofifo_valid;
   logic        ofifo_rd;
   logic        psum_wr;
   logic [2:0]  psum_addr;
   logic        acc;
   logic        relu;

   int   checks    = 0;
   int   failures  = 0;
   int   doneSeen  = 0;
   int   runCyc    = 0;
   exp_t rdQ[$];
   exp_t wrQ[$];
   exp_t psQ[$];

   kij_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .kij_len     (kij_len),
      .acc_en      (acc_en),
      .relu_en     (relu_en),
      .busy        (busy),
      .done        (done),
      .xmem_rd     (xmem_rd),
      .xmem_addr   (xmem_addr),
      .xmem_dout   (xmem_dout),
      .l0_wr       (l0_wr),
      .l0_din      (l0_din),
      .l0_full     (l0_full),
      .inst_w      (inst_w),
      .ofifo_valid (ofifo_valid),
      .ofifo_rd    (ofifo_rd),
      .psum_wr     (psum_wr),
      .psum_addr   (psum_addr),
      .acc         (acc),
      .relu        (relu)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Address-tagged xmem contents so every word is distinguishable.
   function automatic logic [31:0] memWord(input logic [10:0] a);
      return {8'hC3, 5'b0, a, 8'h3C};
   endfunction

   // xmem model: one-cycle read latency.
   always @(posedge clk) begin
      if (xmem_rd) xmem_dout <= memWord(xmem_addr);
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Queue the full expected trace of a run. With no backpressure and OFIFO always valid
   // every pass is 31 cycles: LOAD_W 5, SETTLE 8, EXEC 9, DRAIN 8, NEXT 1, so event
   // cycles (counted from the cycle after start) are known exactly.
   task automatic pushRun(input int kLen, input bit accE, input bit reluE, input bit timed);
      exp_t e;
      for (int k = 0; k < kLen; k++) begin
         for (int c = 0; c < 4; c++) begin
            e.val = 32'(k * 4 + c);
            e.cyc = timed ? 31 * k + 1 + c : -1;
            rdQ.push_back(e);
            e.val = memWord(11'(k * 4 + c));
            e.cyc = timed ? 31 * k + 2 + c : -1;
            wrQ.push_back(e);
         end
         for (int i = 0; i < 8; i++) begin
            e.val = 32'(1024 + k * 8 + i);
            e.cyc = timed ? 31 * k + 14 + i : -1;
            rdQ.push_back(e);
            e.val = memWord(11'(1024 + k * 8 + i));
            e.cyc = timed ? 31 * k + 15 + i : -1;
            wrQ.push_back(e);
         end
         for (int i = 0; i < 8; i++) begin
            e.val = {27'd0, 3'(i), (accE && k > 0), (reluE && k == kLen - 1)};
            e.cyc = timed ? 31 * k + 23 + i : -1;
            psQ.push_back(e);
         end
      end
   endtask

   // Scoreboard monitor: pops an expectation for every read, L0 write and psum write.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (xmem_rd) begin
            if (rdQ.size() > 0) e = rdQ.pop_front();
            else begin e.val = 'x; e.cyc = -1; end
            checkOutput("xmem_addr", 64'(xmem_addr), 64'(e.val));
            checkOutput("inst_w_on_read", 64'(inst_w), (e.val >= 1024) ? 64'd2 : 64'd1);
            if (e.cyc >= 0) checkOutput("xmem_rd_cycle", 64'(runCyc), 64'(e.cyc));
         end
         if (l0_wr) begin
            if (wrQ.size() > 0) e = wrQ.pop_front();
            else begin e.val = 'x; e.cyc = -1; end
            checkOutput("l0_din", 64'(l0_din), 64'(e.val));
            if (e.cyc >= 0) checkOutput("l0_wr_cycle", 64'(runCyc), 64'(e.cyc));
         end
         if (psum_wr) begin
            if (psQ.size() > 0) e = psQ.pop_front();
            else begin e.val = 'x; e.cyc = -1; end
            checkOutput("psum_addr_acc_relu", 64'({psum_addr, acc, relu}), 64'(e.val));
            checkOutput("ofifo_rd_with_psum", 64'(ofifo_rd), 64'd1);
            checkOutput("psum_needs_valid", 64'(ofifo_valid), 64'd1);
            if (e.cyc >= 0) checkOutput("psum_wr_cycle", 64'(runCyc), 64'(e.cyc));
         end else begin
            checkOutput("pop_without_psum", 64'(ofifo_rd), 64'd0);
         end
         if (done) doneSeen++;
      end
   end

   // Launch one run and wait (bounded) for done, optionally toggling ofifo_valid 1,0,0,1,
   // backpressuring L0 for 3 cycles while activation word 1026 is in flight, and
   // re-pulsing start at cycle restartAt to confirm it is ignored.
   task automatic applyStimulus(input string name, input int kLen, input bit accE, input bit reluE,
                                input bit togValid, input bit bpOn, input int restartAt);
      logic [3:0] validPat = 4'b1001;
      bit  gotDone = 0;
      bit  bpArmed = bpOn;
      int  bpCnt   = 0;
      int  doneAt  = 0;
      int  d0;
      pushRun(kLen, accE, reluE, !togValid && !bpOn);
      d0 = doneSeen;
      @(posedge clk); #1;
      kij_len = 4'(kLen);
      acc_en  = accE;
      relu_en = reluE;
      start   = 1'b1;
      for (int i = 1; i <= 600 && !gotDone; i++) begin
         @(posedge clk); #1;
         runCyc = i;
         start  = (i == restartAt);
         if (i == restartAt) kij_len = 4'd1;
         l0_full = (bpCnt > 0);
         if (bpCnt > 0) bpCnt--;
         ofifo_valid = togValid ? validPat[(i - 1) % 4] : 1'b1;
         @(negedge clk);
         if (i == 1) checkOutput({name, "_busy_rise"}, 64'(busy), 64'd1);
         if (bpArmed && xmem_rd && xmem_addr == 11'd1026) begin
            bpCnt   = 3;
            bpArmed = 0;
         end
         if (done) begin
            gotDone = 1;
            doneAt  = i;
            checkOutput({name, "_busy_fall_with_done"}, 64'(busy), 64'd0);
         end
      end
      @(posedge clk); #1;
      start       = 1'b0;
      l0_full     = 1'b0;
      ofifo_valid = 1'b1;
      runCyc      = -1000;
      checkOutput({name, "_done_seen"}, 64'(gotDone), 64'd1);
      if (!togValid && !bpOn) checkOutput({name, "_done_cycle"}, 64'(doneAt), 64'(31 * kLen + 2));
      repeat (4) @(negedge clk);
      checkOutput({name, "_reads_left"}, 64'(rdQ.size()), 64'd0);
      checkOutput({name, "_l0_writes_left"}, 64'(wrQ.size()), 64'd0);
      checkOutput({name, "_psum_writes_left"}, 64'(psQ.size()), 64'd0);
      checkOutput({name, "_done_count"}, 64'(doneSeen - d0), 64'd1);
      $display("[TB] %s run complete", name);
   endtask

   // Global time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] global time limit reached");
   end

   // Directed sequence.
   initial begin
      bit seenExec;
      int d0;
      reset_n     = 1'b0;
      start       = 1'b0;
      kij_len     = '0;
      acc_en      = 1'b0;
      relu_en     = 1'b0;
      l0_full     = 1'b0;
      ofifo_valid = 1'b1;

      @(negedge clk);
      checkOutput("reset_outputs_zero",
                  64'({busy, done, xmem_rd, xmem_addr, l0_wr, l0_din, inst_w, ofifo_rd, psum_wr, psum_addr, acc, relu}), 64'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle_busy", 64'(busy), 64'd0);

      applyStimulus("basic",  1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      applyStimulus("multi",  3, 1'b1, 1'b1, 1'b0, 1'b0, 5);
      applyStimulus("l0bp",   1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      applyStimulus("toggle", 2, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      applyStimulus("zero",   0, 1'b1, 1'b1, 1'b0, 1'b0, 1);

      // Abort a run mid-EXEC with reset, then rerun the basic scenario.
      pushRun(1, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      kij_len = 4'd1;
      acc_en  = 1'b0;
      relu_en = 1'b1;
      start   = 1'b1;
      seenExec = 0;
      for (int i = 1; i <= 100 && !seenExec; i++) begin
         @(posedge clk); #1;
         runCyc = i;
         start  = 1'b0;
         @(negedge clk);
         if (xmem_rd && xmem_addr == 11'd1027) seenExec = 1;
      end
      checkOutput("abort_reached_exec", 64'(seenExec), 64'd1);
      d0 = doneSeen;
      @(posedge clk); #1 reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("abort_outputs_zero",
                     64'({busy, done, xmem_rd, xmem_addr, l0_wr, l0_din, inst_w, ofifo_rd, psum_wr, psum_addr, acc, relu}), 64'd0);
      end
      rdQ.delete();
      wrQ.delete();
      psQ.delete();
      runCyc = -1000;
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("abort_no_stale_done", 64'(doneSeen - d0), 64'd0);
      checkOutput("abort_busy_low", 64'(busy), 64'd0);

      applyStimulus("rerun", 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
